// File: rtl/axil_slv_mem.sv
// axil_slv_mem: AXI4-Lite slave backed by a DEPTH x DATA_W memory.
// Define AXIL_SLV_MEM_ERR_EN to answer out-of-range words with SLVERR.
module axil_slv_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready
);

  localparam int NB    = DATA_W / 8;
  localparam int BSH   = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [3:0] LAT_END = 4'(RD_LAT - 1);
  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] SLVERR  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } r_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  w_state_t w_state;
  r_state_t r_state;

  logic              run;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [NB-1:0]     w_strb_q;
  logic [3:0]        lat_cnt;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic [NB-1:0]     c_strb;
  logic [IDX_W-1:0]  c_idx;
  logic [IDX_W-1:0]  ar_idx;
  logic              c_err;
  logic              ar_err;

  function automatic logic [IDX_W-1:0] word_idx(
    input logic [ADDR_W-1:0] a
  );
    return IDX_W'(a >> BSH);
  endfunction

`ifdef AXIL_SLV_MEM_ERR_EN
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  assign c_err  = (c_addr >> BSH) >= DEPTH_A;
  assign ar_err = (s_araddr >> BSH) >= DEPTH_A;
`else
  assign c_err  = 1'b0;
  assign ar_err = 1'b0;
`endif

  assign aw_hs  = s_awvalid & s_awready;
  assign w_hs   = s_wvalid & s_wready;
  assign ar_hs  = s_arvalid & s_arready;
  assign c_idx  = word_idx(c_addr);
  assign ar_idx = word_idx(s_araddr);

  // Commit fires when the second half of AW/W lands; pick held or live fields
  always_comb begin
    commit = 1'b0;
    c_addr = s_awaddr;
    c_data = s_wdata;
    c_strb = s_wstrb;
    unique case (w_state)
      W_IDLE: begin
        commit = aw_hs & w_hs;
      end
      W_HAVE_AW: begin
        commit = w_hs;
        c_addr = aw_addr_q;
      end
      W_HAVE_W: begin
        commit = aw_hs;
        c_data = w_data_q;
        c_strb = w_strb_q;
      end
      default: begin
        commit = 1'b0;
      end
    endcase
  end

  // Delays the first ready by one edge after reset release
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  // Write FSM with registered ready/response outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state   <= W_IDLE;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      w_state   <= W_RESP;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b1;
      s_bresp   <= c_err ? SLVERR : OKAY;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_state   <= W_HAVE_AW;
            aw_addr_q <= s_awaddr;
            s_awready <= 1'b0;
            s_wready  <= 1'b1;
          end else if (w_hs) begin
            w_state   <= W_HAVE_W;
            w_data_q  <= s_wdata;
            w_strb_q  <= s_wstrb;
            s_awready <= 1'b1;
            s_wready  <= 1'b0;
          end else begin
            s_awready <= run;
            s_wready  <= run;
          end
        end
        W_HAVE_AW, W_HAVE_W: begin
        end
        W_RESP: begin
          if (s_bready) begin
            w_state   <= W_IDLE;
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
          end
        end
        default: begin
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  // Byte-masked memory update; contents survive reset
  always_ff @(posedge aclk) begin
    if (commit && !c_err) begin
      for (int b = 0; b < NB; b++) begin
        if (c_strb[b]) begin
          mem[c_idx][b*8 +: 8] <= c_data[b*8 +: 8];
        end
      end
    end
  end

  // Read FSM: data captured at AR, released after RD_LAT cycles
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= OKAY;
      lat_cnt   <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            s_arready <= 1'b0;
            s_rdata   <= ar_err ? '0 : mem[ar_idx];
            s_rresp   <= ar_err ? SLVERR : OKAY;
            lat_cnt   <= 4'd1;
            if (RD_LAT <= 1) begin
              r_state  <= R_RESP;
              s_rvalid <= 1'b1;
            end else begin
              r_state <= R_WAIT;
            end
          end else begin
            s_arready <= run;
          end
        end
        R_WAIT: begin
          if (lat_cnt != 4'hF) begin
            lat_cnt <= lat_cnt + 4'd1;
          end
          if (lat_cnt >= LAT_END) begin
            r_state  <= R_RESP;
            s_rvalid <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            r_state   <= R_IDLE;
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
          end
        end
        default: begin
          r_state <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_slv_mem.sv
// tb_axil_slv_mem: random and directed AXI4-Lite traffic against
// a word-array model; a second instance runs with RD_LAT=4.
module tb_axil_slv_mem;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_bready = 1'b0;
  logic [15:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_rready = 1'b0;

  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  logic        awready4, wready4, bvalid4, arready4, rvalid4;
  logic [1:0]  bresp4, rresp4;
  logic [31:0] rdata4;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl [256];

  always #5 aclk = ~aclk;

  axil_slv_mem #(
    .DATA_W(32), .ADDR_W(16), .DEPTH(256), .RD_LAT(1)
  ) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
    .s_rready(s_rready)
  );

  axil_slv_mem #(
    .DATA_W(32), .ADDR_W(16), .DEPTH(256), .RD_LAT(4)
  ) u_dut4 (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(awready4),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
    .s_wready(wready4),
    .s_bresp(bresp4), .s_bvalid(bvalid4), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(arready4),
    .s_rdata(rdata4), .s_rresp(rresp4), .s_rvalid(rvalid4),
    .s_rready(s_rready)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  function automatic bit m_err(input logic [15:0] a);
    int idx = int'(a) / 4;
`ifdef AXIL_SLV_MEM_ERR_EN
    return idx >= 256;
`else
    return (idx < 0);
`endif
  endfunction

  function automatic logic [31:0] m_rdata(input logic [15:0] a);
    if (m_err(a)) return 32'h0;
    return mdl[(int'(a) / 4) % 256];
  endfunction

  function automatic logic [1:0] m_resp(input logic [15:0] a);
    return m_err(a) ? 2'b10 : 2'b00;
  endfunction

  task automatic m_write(input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] st);
    int w;
    logic [31:0] v;
    if (m_err(a)) return;
    w = (int'(a) / 4) % 256;
    v = mdl[w];
    for (int b = 0; b < 4; b++) begin
      if (st[b]) v[b*8 +: 8] = d[b*8 +: 8];
    end
    mdl[w] = v;
  endtask

  task automatic finish_write(input logic [1:0] er, input int b_dly);
    chk("bvalid_rise", {s_bvalid, bvalid4}, 2'b11);
    chk("awready_in_resp", s_awready, 0);
    chk("bresp", {s_bresp, bresp4}, {er, er});
    for (int k = 0; k < b_dly; k++) begin
      tick;
      chk("b_hold", {s_bvalid, s_bresp}, {1'b1, er});
    end
    s_bready = 1'b1;
    tick;
    s_bready = 1'b0;
    chk("bvalid_fall", s_bvalid, 0);
    chk("aw_w_ready_back", {s_awready, s_wready}, 2'b11);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] st, input int aw_dly,
                          input int w_dly, input int b_dly);
    int  n;
    bit  aw_left, w_left, aw_go, w_go;
    logic [1:0] er;
    er = m_resp(a);
    s_awaddr = a;
    s_wdata = d;
    s_wstrb = st;
    aw_left = 1;
    w_left = 1;
    n = 0;
    while ((aw_left || w_left) && n < 40) begin
      s_awvalid = aw_left && (n >= aw_dly);
      s_wvalid = w_left && (n >= w_dly);
      if (!aw_left && w_left) chk("awready_have_aw", s_awready, 0);
      if (aw_left && !w_left) chk("wready_have_w", s_wready, 0);
      aw_go = s_awvalid && s_awready;
      w_go = s_wvalid && s_wready;
      tick;
      n++;
      if (aw_go) aw_left = 0;
      if (w_go) w_left = 0;
    end
    s_awvalid = 1'b0;
    s_wvalid = 1'b0;
    chk("aw_w_accept", {aw_left, w_left}, 0);
    m_write(a, d, st);
    finish_write(er, b_dly);
  endtask

  task automatic issue_ar(input logic [15:0] a);
    int n = 0;
    s_araddr = a;
    s_arvalid = 1'b1;
    while (!(s_arready && arready4) && n < 20) begin
      tick;
      n++;
    end
    chk("ar_ready_timeout", n < 20, 1);
    tick;
    s_arvalid = 1'b0;
  endtask

  task automatic finish_read(input logic [31:0] ed, input logic [1:0] er,
                             input int r_dly);
    int c = 1;
    int l1 = -1;
    int l4 = -1;
    while (c < 20) begin
      if (l1 < 0 && s_rvalid) l1 = c;
      if (l4 < 0 && rvalid4) l4 = c;
      if (s_rvalid) chk("rdata_wait_hold", s_rdata, ed);
      if (l1 >= 0 && l4 >= 0) break;
      tick;
      c++;
    end
    chk("rd_lat1", l1, 1);
    chk("rd_lat4", l4, 4);
    for (int k = 0; k < r_dly; k++) begin
      tick;
      chk("r_hold", {s_rvalid, rvalid4, rdata4}, {2'b11, ed});
    end
    chk("rdata", s_rdata, ed);
    chk("rdata4", rdata4, ed);
    chk("rresp", {s_rresp, rresp4}, {er, er});
    s_rready = 1'b1;
    tick;
    s_rready = 1'b0;
    chk("rvalid_fall", {s_rvalid, rvalid4}, 0);
    chk("arready_back", {s_arready, arready4}, 2'b11);
  endtask

  task automatic do_read(input logic [15:0] a, input int r_dly);
    issue_ar(a);
    finish_read(m_rdata(a), m_resp(a), r_dly);
  endtask

  task automatic do_rw(input logic [15:0] wa, input logic [31:0] d,
                       input logic [3:0] st, input logic [15:0] ra);
    logic [31:0] ed;
    logic [1:0] er;
    s_awaddr = wa;
    s_wdata = d;
    s_wstrb = st;
    s_araddr = ra;
    chk("all_ready", {s_awready, s_wready, s_arready}, 3'b111);
    ed = m_rdata(ra);
    er = m_resp(ra);
    s_awvalid = 1'b1;
    s_wvalid = 1'b1;
    s_arvalid = 1'b1;
    tick;
    s_awvalid = 1'b0;
    s_wvalid = 1'b0;
    s_arvalid = 1'b0;
    m_write(wa, d, st);
    finish_read(ed, er, 1);
    finish_write(m_resp(wa), 0);
  endtask

  task automatic reset_pulse;
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst_outs", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                     s_bresp, s_rresp, s_rdata}, 0);
    chk("rst_outs4", {awready4, wready4, arready4, bvalid4, rvalid4,
                      bresp4, rresp4, rdata4}, 0);
    #2;
    aresetn = 1'b1;
    tick;
    chk("rdy_edge1", {s_awready, s_wready, s_arready, arready4}, 0);
    tick;
    chk("rdy_edge2", {s_awready, s_wready, s_arready, arready4}, 4'hF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old;
    repeat (3) tick;
    reset_pulse();

    for (int i = 0; i < 256; i++) begin
      do_write(16'(i * 4), $urandom, 4'hF, 0, 0, 0);
    end

    do_write(16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(16'h0010, 0);

    do_write(16'h0040, 32'h0BADF00D, 4'hF, 3, 0, 2);
    do_read(16'h0040, 0);
    do_write(16'h0044, 32'h12345678, 4'hF, 0, 2, 1);
    do_read(16'h0044, 0);

    do_write(16'h0050, 32'h11223344, 4'hF, 0, 0, 0);
    do_write(16'h0050, 32'hAABBCCDD, 4'h3, 0, 0, 0);
    do_read(16'h0052, 0);

    do_read(16'h0010, 5);

    do_write(16'h0400, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    do_read(16'h0400, 0);
    do_read(16'h0000, 0);

    do_write(16'h0020, 32'h5, 4'hF, 0, 0, 0);
    do_rw(16'h0020, 32'h9, 4'hF, 16'h0020);
    do_read(16'h0020, 0);

    issue_ar(16'h0020);
    reset_pulse();
    do_read(16'h0020, 0);

    old = m_rdata(16'h0080);
    s_awaddr = 16'h0080;
    s_awvalid = 1'b1;
    tick;
    s_awvalid = 1'b0;
    chk("have_aw_rdy", {s_awready, s_wready}, 2'b01);
    reset_pulse();
    do_read(16'h0080, 0);
    chk("rst_no_commit", s_rdata, old);

    s_wdata = 32'hFFFFFFFF;
    s_wstrb = 4'hF;
    s_wvalid = 1'b1;
    tick;
    s_wvalid = 1'b0;
    chk("have_w_rdy", {s_awready, s_wready}, 2'b10);
    reset_pulse();
    do_read(16'h0080, 0);

    for (int i = 0; i < 200; i++) begin
      int op;
      int idx;
      logic [15:0] a;
      logic [15:0] b;
      op = $urandom_range(0, 2);
      idx = ($urandom_range(0, 7) == 0) ? $urandom_range(256, 511)
                                        : $urandom_range(0, 255);
      a = 16'(idx * 4 + $urandom_range(0, 3));
      b = ($urandom_range(0, 1) == 0) ? a : 16'($urandom_range(0, 1023));
      unique case (op)
        0: do_write(a, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2));
        1: do_read(a, $urandom_range(0, 2));
        default: do_rw(a, $urandom, 4'($urandom_range(0, 15)), b);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
